// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM.
// Port 0 has priority; port 1 is forced through after MAX_WAIT consecutive denied cycles.
module sram_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [15:0]       conflict_cnt
);

  typedef struct packed {
    logic valid;
    logic owner;   // 0 = port 0, 1 = port 1
  } rd_tag_t;

  logic [3:0]        r_wait_cnt;
  logic [15:0]       r_conflict_cnt;
  logic              r_sram_ce;
  logic              r_sram_we;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_din;
  rd_tag_t           r_tag1;
  rd_tag_t           r_tag2;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_force1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_we_sel;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_din_sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_force1   = 1'b0;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_we_sel   = we0;
    w_addr_sel = addr0;
    w_din_sel  = wdata0;
    if (!rst) begin
      w_force1 = req1 && (r_wait_cnt >= 4'(MAX_WAIT));
      w_gnt0   = req0 && !w_force1;
      w_gnt1   = req1 && (!req0 || w_force1);
    end
    if (w_gnt1) begin
      w_we_sel   = we1;
      w_addr_sel = addr1;
      w_din_sel  = wdata1;
    end
  end

  // Grants already imply req, so either grant is an accept.
  assign w_acc = w_gnt0 || w_gnt1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt     <= '0;
      r_conflict_cnt <= '0;
      r_sram_ce      <= 1'b0;
      r_sram_we      <= 1'b0;
      r_sram_addr    <= '0;
      r_sram_din     <= '0;
      r_tag1         <= '0;
      r_tag2         <= '0;
      r_rvalid0      <= 1'b0;
      r_rvalid1      <= 1'b0;
      r_rdata0       <= '0;
      r_rdata1       <= '0;
    end else begin
      if (req1 && !w_gnt1) begin
        if (r_wait_cnt != 4'hF) r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (req0 && req1 && (r_conflict_cnt != 16'hFFFF))
        r_conflict_cnt <= r_conflict_cnt + 16'd1;

      r_sram_ce <= w_acc;
      r_sram_we <= w_acc && w_we_sel;
      if (w_acc) begin
        r_sram_addr <= w_addr_sel;
        r_sram_din  <= w_din_sel;
      end

      // Tag follows the access: SRAM samples in N+1, data appears in N+2, return in N+3.
      r_tag1.valid <= w_acc && !w_we_sel;
      r_tag1.owner <= w_gnt1;
      r_tag2       <= r_tag1;

      r_rvalid0 <= r_tag2.valid && !r_tag2.owner;
      r_rvalid1 <= r_tag2.valid &&  r_tag2.owner;
      if (r_tag2.valid && !r_tag2.owner) r_rdata0 <= sram_dout;
      if (r_tag2.valid &&  r_tag2.owner) r_rdata1 <= sram_dout;
    end
  end

  assign gnt0         = w_gnt0;
  assign gnt1         = w_gnt1;
  assign sram_ce      = r_sram_ce;
  assign sram_we      = r_sram_we;
  assign sram_addr    = r_sram_addr;
  assign sram_din     = r_sram_din;
  assign rvalid0      = r_rvalid0;
  assign rvalid1      = r_rvalid1;
  assign rdata0       = r_rdata0;
  assign rdata1       = r_rdata1;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural one-cycle-latency SRAM.
module tb_sram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              sram_ce, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din, sram_dout;
  logic [15:0]       conflict_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_conf = '0;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout      <= mem[sram_addr];
    end
  end

  // Advance one cycle; the expected conflict count tracks what was driven this cycle.
  task automatic cyc();
    if (rst) exp_conf = '0;
    else if (req0 && req1 && exp_conf != 16'hFFFF) exp_conf = exp_conf + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic test_reset();
    rst = 1; req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    addr0 = 10'h155; addr1 = 10'h2AA; wdata0 = 8'h5A; wdata1 = 8'hC3;
    cyc();
    #1;
    tests++;
    if ({gnt0, gnt1} !== 2'b00) begin
      fails++; $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1});
    end
    tests++;
    if ({sram_ce, sram_we, sram_addr, sram_din, rvalid0, rvalid1, rdata0, rdata1, conflict_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ce=%b we=%b addr=%h din=%h rv=%b%b rd0=%h rd1=%h cc=%h want all 0",
               sram_ce, sram_we, sram_addr, sram_din, rvalid0, rvalid1, rdata0, rdata1, conflict_cnt);
    end
    cyc();
  endtask

  // Write 0x005=0xA5 in the first cycle out of reset, read it back the next cycle.
  task automatic test_write_read();
    rst = 0; idle();
    req0 = 1; we0 = 1; addr0 = 10'h005; wdata0 = 8'hA5;
    #1;
    tests++;
    if ({gnt0, gnt1} !== 2'b10) begin
      fails++; $display("FAIL first_accept_gnt: got %b want 10", {gnt0, gnt1});
    end
    cyc();
    we0 = 0;
    #1;
    tests++;
    if ({sram_ce, sram_we, sram_addr, sram_din} !== {1'b1, 1'b1, 10'h005, 8'hA5}) begin
      fails++; $display("FAIL wr_issue: ce=%b we=%b addr=%h din=%h want 1 1 005 a5",
                        sram_ce, sram_we, sram_addr, sram_din);
    end
    cyc();
    idle();
    #1;
    tests++;
    if ({sram_ce, sram_we, sram_addr} !== {1'b1, 1'b0, 10'h005}) begin
      fails++; $display("FAIL rd_issue: ce=%b we=%b addr=%h want 1 0 005", sram_ce, sram_we, sram_addr);
    end
    cyc();
    #1;
    tests++;
    if ({sram_ce, sram_we, sram_addr, rvalid0, rvalid1} !== {1'b0, 1'b0, 10'h005, 1'b0, 1'b0}) begin
      fails++; $display("FAIL idle_hold_no_wr_rvalid: ce=%b we=%b addr=%h rv=%b%b want 0 0 005 00",
                        sram_ce, sram_we, sram_addr, rvalid0, rvalid1);
    end
    cyc();
    #1;
    tests++;
    if ({rvalid0, rvalid1, rdata0} !== {1'b1, 1'b0, 8'hA5}) begin
      fails++; $display("FAIL raw_return: rv=%b%b rd0=%h want 10 a5", rvalid0, rvalid1, rdata0);
    end
    cyc();
    #1;
    tests++;
    if ({rvalid0, rdata0} !== {1'b0, 8'hA5}) begin
      fails++; $display("FAIL rdata_hold: rv0=%b rd0=%h want 0 a5", rvalid0, rdata0);
    end
  endtask

  task automatic test_interleaved();
    idle();
    req0 = 1; we0 = 1; addr0 = 10'h001; wdata0 = 8'h11;
    cyc();
    idle();
    req1 = 1; we1 = 1; addr1 = 10'h002; wdata1 = 8'h22;
    cyc();
    idle();
    req0 = 1; addr0 = 10'h001;
    cyc();
    idle();
    req1 = 1; addr1 = 10'h002;
    #1;
    tests++;
    if ({gnt0, gnt1} !== 2'b01) begin
      fails++; $display("FAIL p1_alone_gnt: got %b want 01", {gnt0, gnt1});
    end
    cyc();
    idle();
    cyc();
    #1;
    tests++;
    if ({rvalid0, rvalid1, rdata0} !== {1'b1, 1'b0, 8'h11}) begin
      fails++; $display("FAIL ilv_port0: rv=%b%b rd0=%h want 10 11", rvalid0, rvalid1, rdata0);
    end
    cyc();
    #1;
    tests++;
    if ({rvalid0, rvalid1, rdata1, rdata0} !== {1'b0, 1'b1, 8'h22, 8'h11}) begin
      fails++; $display("FAIL ilv_port1: rv=%b%b rd1=%h rd0=%h want 01 22 11", rvalid0, rvalid1, rdata1, rdata0);
    end
    cyc();
    cyc();
  endtask

  // Both ports requesting: port 1 forced through on every 5th cycle.
  task automatic test_contention();
    logic exp_g1;
    int   bad_gnt = 0;
    int   bad_cc  = 0;
    idle();
    req0 = 1; req1 = 1; addr0 = 10'h001; addr1 = 10'h002;
    for (int k = 0; k < 20; k++) begin
      #1;
      exp_g1 = ((k % 5) == 4);
      tests++;
      if ({gnt0, gnt1} !== {~exp_g1, exp_g1}) begin
        fails++; bad_gnt++;
        $display("FAIL contention_gnt cycle %0d: got %b want %b", k, {gnt0, gnt1}, {~exp_g1, exp_g1});
      end
      tests++;
      if (conflict_cnt !== exp_conf) begin
        fails++; bad_cc++;
        $display("FAIL contention_cnt cycle %0d: got %h want %h", k, conflict_cnt, exp_conf);
      end
      cyc();
    end
    idle();
    for (int k = 0; k < 4; k++) cyc();
  endtask

  // Port 1 denied twice, withdraws, re-requests: the wait count restarts from zero.
  task automatic test_withdraw();
    logic exp_g1;
    idle();
    req0 = 1; addr0 = 10'h001;
    we1 = 1; addr1 = 10'h3FF; wdata1 = 8'h77;
    for (int c = 0; c < 8; c++) begin
      req1 = (c != 2);
      #1;
      exp_g1 = (c == 7);
      tests++;
      if ({gnt0, gnt1} !== {~exp_g1, exp_g1}) begin
        fails++; $display("FAIL withdraw_gnt cycle %0d: got %b want %b", c, {gnt0, gnt1}, {~exp_g1, exp_g1});
      end
      if (c >= 1) begin
        tests++;
        if ({sram_ce, sram_we, sram_addr} !== {1'b1, 1'b0, 10'h001}) begin
          fails++; $display("FAIL withdraw_no_p1_access cycle %0d: ce=%b we=%b addr=%h want 1 0 001",
                            c, sram_ce, sram_we, sram_addr);
        end
      end
      cyc();
    end
    idle();
    #1;
    tests++;
    if ({sram_ce, sram_we, sram_addr, sram_din} !== {1'b1, 1'b1, 10'h3FF, 8'h77}) begin
      fails++; $display("FAIL withdraw_p1_write: ce=%b we=%b addr=%h din=%h want 1 1 3ff 77",
                        sram_ce, sram_we, sram_addr, sram_din);
    end
    for (int k = 0; k < 4; k++) cyc();
  endtask

  task automatic test_reset_midflight();
    idle();
    req1 = 1; addr1 = 10'h002;
    #1;
    tests++;
    if (gnt1 !== 1'b1) begin
      fails++; $display("FAIL midflight_accept: gnt1=%b want 1", gnt1);
    end
    cyc();
    rst = 1; req0 = 1; req1 = 1;
    #1;
    tests++;
    if ({gnt0, gnt1} !== 2'b00) begin
      fails++; $display("FAIL midflight_rst_gnt: got %b want 00", {gnt0, gnt1});
    end
    cyc();
    #1;
    tests++;
    if ({gnt0, gnt1, sram_ce, sram_we, sram_addr, sram_din, rvalid0, rvalid1, rdata0, rdata1, conflict_cnt} !== '0) begin
      fails++;
      $display("FAIL midflight_rst_outputs: g=%b%b ce=%b we=%b addr=%h din=%h rv=%b%b rd0=%h rd1=%h cc=%h want all 0",
               gnt0, gnt1, sram_ce, sram_we, sram_addr, sram_din, rvalid0, rvalid1, rdata0, rdata1, conflict_cnt);
    end
    cyc();
    rst = 0; idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
        fails++; $display("FAIL midflight_no_rvalid cycle %0d: rv=%b%b want 00", k, rvalid0, rvalid1);
      end
      cyc();
    end
  endtask

  task automatic test_saturation();
    idle();
    req0 = 1; req1 = 1; addr0 = 10'h001; addr1 = 10'h002;
    for (int k = 0; k < 70000; k++) cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (conflict_cnt !== 16'hFFFF) begin
        fails++; $display("FAIL saturation cycle %0d: got %h want ffff", k, conflict_cnt);
      end
      cyc();
    end
    idle();
    cyc();
  endtask

  initial begin
    rst = 1; idle();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_interleaved();
    test_contention();
    test_withdraw();
    test_reset_midflight();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, meaning SRAM address width.
REQ-002 Parameter DATA_W, default 8, meaning SRAM data width.
REQ-003 Parameter MAX_WAIT, default 4, meaning consecutive denied cycles after which port 1 is forced to win (range 1..15).
REQ-004 clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-006 req0/req1  input  1 each  port 0 (host loader) and port 1 (tile processor) access request.
REQ-007 we0/we1  input  1 each  1 means write, 0 means read; qualified by req.
REQ-008 addr0/addr1  input  ADDR_W each  access address.
REQ-009 wdata0/wdata1  input  DATA_W each  write data.
REQ-010 gnt0/gnt1  output  1 each  combinational grant; the access is accepted in a cycle when req and gnt are both high.
REQ-011 rvalid0/rvalid1  output  1 each  single-cycle read-return strobe.
REQ-012 rdata0/rdata1  output  DATA_W each  read-return data, valid with rvalid.
REQ-013 sram_ce, sram_we  output  1 each  registered SRAM enable and write strobe.
REQ-014 sram_addr  output  ADDR_W  registered SRAM address.
REQ-015 sram_din  output  DATA_W  registered SRAM write data.
REQ-016 sram_dout  input  DATA_W  SRAM read data, valid one cycle after the SRAM samples a read.
REQ-017 conflict_cnt  output  16  saturating count of cycles with req0 and req1 both high.

Function
REQ-018 At most one of gnt0/gnt1 is high in any cycle, and a grant is never given to a port whose req is low.
REQ-019 Default priority: port 0 wins when both ports request.
REQ-020 wait_cnt (4 bits) increments each cycle req1=1 and gnt1=0, and clears in any cycle gnt1=1 or req1=0.
REQ-021 When wait_cnt >= MAX_WAIT and req1=1, port 1 wins over port 0 that cycle.
REQ-022 Accept in cycle N: in cycle N+1, sram_ce=1, sram_we=we, sram_addr=addr and sram_din=wdata of the winning port.
REQ-023 In cycles with no accept, the next cycle drives sram_ce=0 and sram_we=0, and sram_addr/sram_din hold their values.
REQ-024 Read accepted in cycle N: rvalid of the owning port is high in cycle N+3 only, and rdata carries the sram_dout captured in N+2.
REQ-025 A write accept produces no rvalid.
REQ-026 Read returns are tracked by a 2-stage {valid, owner} pipeline, giving full throughput: one accept per cycle, back-to-back, with mixed owners.
REQ-027 Accesses reach the SRAM in accept order, so a read accepted the cycle after a write to the same address returns the new data.
REQ-028 A requester may drop req before being granted; no state is retained for that request.
REQ-029 rdata0/rdata1 hold their last value when rvalid is low.
REQ-030 conflict_cnt saturates at 0xFFFF and does not wrap.

Reset
REQ-031 While rst=1: gnt0=gnt1=0; sram_ce=sram_we=0; sram_addr, sram_din, rdata0, rdata1, conflict_cnt, wait_cnt = 0; rvalid0=rvalid1=0.
REQ-032 Assertion of rst mid-operation discards all in-flight reads, so no rvalid occurs for them after rst deasserts.
REQ-033 The first accept is possible in the first cycle with rst=0.

Verification
REQ-034 Single write then read: port 0 writes addr 0x005 data 0xA5 in cycle N, then reads 0x005 in N+1 -> sram_we=1 in N+1, rvalid0=1 with rdata0=0xA5 in N+4.
REQ-035 Contention: req0 and req1 held high continuously with MAX_WAIT=4 -> gnt1 asserted once every 5th cycle, never both grants high, conflict_cnt increments every cycle.
REQ-036 Interleaved reads: port 0 reads 0x001 and port 1 reads 0x002 in consecutive cycles -> rvalid0 then rvalid1 in consecutive cycles, each with the correct data and no cross-delivery.
REQ-037 Reset mid-flight: port 1 read accepted, rst pulsed high one cycle later -> rvalid1 never asserted, all outputs zero during reset.
REQ-038 Saturation: conflict forced for 70000 cycles -> conflict_cnt = 0xFFFF and holds.
REQ-039 Withdrawn request: req1 dropped after 2 denied cycles, then re-raised -> wait_cnt restarts from 0, and no spurious SRAM access is issued for port 1.
